// File: rtl/sprite_fetch_arbiter.sv
// -----------------------------------------------------------------------------
// sprite_fetch_arbiter
//
// Arbitrates NREQ sprite fetch requesters onto one shared single-port sprite
// ROM with a 1-cycle registered read. Accepts one beat per cycle with no
// bubbles. A beat granted at edge E0 drives rom_addr after E0. Its response
// (rsp_valid one-hot plus rsp_data) appears after E1.
//
// A requester may hold the port for a sprite row by asserting req_lock. The
// lock is released when any of these happens:
//   - the owner drops its lock on a granted beat;
//   - the owner drops req;
//   - the owner has taken MAX_BURST consecutive beats while someone else waits.
// With nobody else waiting, the lock persists past MAX_BURST.
//
// Configuration macro:
//   SPRITE_ARB_RR_EN  defined   -> round-robin pointer. It moves past the
//                                  requester whose grant sequence just ended.
//                     undefined -> fixed priority, index 0 highest.
//
// Ports:
//   clk        in   clock; all state changes on its rising edge
//   reset      in   asynchronous active-high reset
//   req        in   [NREQ]     per-requester read request
//   req_addr   in   [NREQ*AW]  packed addresses; requester i at [i*AW +: AW]
//   req_lock   in   [NREQ]     keep the grant after this beat
//   gnt        out  [NREQ]     combinational one-hot/zero grant
//   rom_addr   out  [AW]       registered ROM address; holds when idle
//   rom_q      in   [DW]       ROM read data
//   rsp_valid  out  [NREQ]     one-hot owner of rsp_data
//   rsp_data   out  [DW]       rom_q when any rsp_valid bit is set, else 0
// -----------------------------------------------------------------------------
module sprite_fetch_arbiter #(
  parameter int NREQ      = 4,
  parameter int AW        = 10,
  parameter int DW        = 3,
  parameter int MAX_BURST = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NREQ-1:0]    req,
  input  logic [NREQ*AW-1:0] req_addr,
  input  logic [NREQ-1:0]    req_lock,
  output logic [NREQ-1:0]    gnt,
  output logic [AW-1:0]      rom_addr,
  input  logic [DW-1:0]      rom_q,
  output logic [NREQ-1:0]    rsp_valid,
  output logic [DW-1:0]      rsp_data
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW = $clog2(MAX_BURST + 1);
  localparam logic [CW-1:0]   CNT_MAX  = CW'(MAX_BURST);
  localparam logic [CW-1:0]   CNT_ONE  = CW'(1);
  localparam logic [IW-1:0]   IDX_LAST = IW'(NREQ - 1);
  localparam logic [IW-1:0]   IDX_ONE  = IW'(1);
  localparam logic [NREQ-1:0] ONE_HOT0 = NREQ'(1);

`ifdef SPRITE_ARB_RR_EN
  localparam bit RR_EN = 1'b1;
`else
  localparam bit RR_EN = 1'b0;
`endif

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  state_t          state_r;
  logic [IW-1:0]   ptr_r;
  logic [IW-1:0]   owner_r;
  logic [CW-1:0]   cnt_r;
  logic [NREQ-1:0] beat_r;       // beat accepted last edge, ROM read in flight
  logic [NREQ-1:0] rsp_valid_r;
  logic [AW-1:0]   rom_addr_r;

  logic            hi_found_s;
  logic            lo_found_s;
  logic [IW-1:0]   hi_sel_s;
  logic [IW-1:0]   lo_sel_s;
  logic [IW-1:0]   arb_sel_s;
  logic [IW-1:0]   gidx_s;
  logic [NREQ-1:0] gnt_s;
  logic [NREQ-1:0] owner_mask_s;
  logic            any_gnt_s;
  logic            others_s;
  logic [CW-1:0]   cnt_inc_s;
  logic [AW-1:0]   gaddr_s;

  // Pointer value after a grant sequence to idx ends.
  function automatic logic [IW-1:0] next_ptr(input logic [IW-1:0] idx);
    if (!RR_EN || (idx == IDX_LAST)) begin
      return '0;
    end else begin
      return idx + IDX_ONE;
    end
  endfunction

  // Cyclic search from ptr.
  // hi_* = lowest request at or above ptr; lo_* = lowest request overall (wrap).
  always_comb begin
    hi_found_s = 1'b0;
    hi_sel_s   = '0;
    lo_found_s = 1'b0;
    lo_sel_s   = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (req[i]) begin
        lo_found_s = 1'b1;
        lo_sel_s   = IW'(i);
        if (IW'(i) >= ptr_r) begin
          hi_found_s = 1'b1;
          hi_sel_s   = IW'(i);
        end else begin
          hi_found_s = hi_found_s;
        end
      end else begin
        lo_found_s = lo_found_s;
      end
    end
    arb_sel_s = hi_found_s ? hi_sel_s : lo_sel_s;
  end

  // Grant generation: the owner only while locked, the arbiter choice otherwise.
  always_comb begin
    owner_mask_s = ONE_HOT0 << owner_r;
    others_s     = |(req & ~owner_mask_s);
    cnt_inc_s    = (cnt_r == CNT_MAX) ? cnt_r : (cnt_r + CNT_ONE);
    if (reset) begin
      gnt_s  = '0;
      gidx_s = arb_sel_s;
    end else if (state_r == LOCKED) begin
      gnt_s  = req & owner_mask_s;
      gidx_s = owner_r;
    end else begin
      gnt_s  = lo_found_s ? (ONE_HOT0 << arb_sel_s) : '0;
      gidx_s = arb_sel_s;
    end
    any_gnt_s = |gnt_s;
  end

  // Address of the granted requester.
  always_comb begin
    gaddr_s = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gidx_s == IW'(i)) begin
        gaddr_s = req_addr[i*AW +: AW];
      end else begin
        gaddr_s = gaddr_s;
      end
    end
  end

  // Lock FSM, burst counter and arbitration pointer.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= IDLE;
      ptr_r   <= '0;
      owner_r <= '0;
      cnt_r   <= '0;
    end else begin
      case (state_r)
        IDLE: begin
          if (any_gnt_s) begin
            if (req_lock[arb_sel_s]) begin
              state_r <= LOCKED;
              owner_r <= arb_sel_s;
              cnt_r   <= CNT_ONE;
            end else begin
              ptr_r <= next_ptr(arb_sel_s);
            end
          end
        end
        LOCKED: begin
          // The exit check uses the count including this beat.
          // The beat that reaches MAX_BURST is therefore the last one
          // while others wait.
          if (!req[owner_r] || !req_lock[owner_r] ||
              ((cnt_inc_s == CNT_MAX) && others_s)) begin
            state_r <= IDLE;
            cnt_r   <= '0;
            ptr_r   <= next_ptr(owner_r);
          end else begin
            cnt_r <= cnt_inc_s;
          end
        end
        default: begin
          state_r <= IDLE;
          cnt_r   <= '0;
        end
      endcase
    end
  end

  // Two-stage response pipeline aligned with the ROM's registered read.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rom_addr_r  <= '0;
      beat_r      <= '0;
      rsp_valid_r <= '0;
    end else begin
      beat_r      <= gnt_s;
      rsp_valid_r <= beat_r;
      if (any_gnt_s) begin
        rom_addr_r <= gaddr_s;
      end
    end
  end

  assign gnt       = gnt_s;
  assign rom_addr  = rom_addr_r;
  assign rsp_valid = rsp_valid_r;
  assign rsp_data  = (|rsp_valid_r) ? rom_q : '0;

endmodule

// File: tb/tb_sprite_fetch_arbiter.sv
module tb_sprite_fetch_arbiter;

  localparam int NREQ = 4;
  localparam int AW   = 10;
  localparam int DW   = 3;
  localparam int MAXB = 32;

`ifdef SPRITE_ARB_RR_EN
  localparam bit RR_EN = 1'b1;
`else
  localparam bit RR_EN = 1'b0;
`endif

  logic               clk = 1'b0;
  logic               reset;
  logic [NREQ-1:0]    req;
  logic [NREQ*AW-1:0] req_addr;
  logic [NREQ-1:0]    req_lock;
  logic [NREQ-1:0]    gnt;
  logic [AW-1:0]      rom_addr;
  logic [DW-1:0]      rom_q;
  logic [NREQ-1:0]    rsp_valid;
  logic [DW-1:0]      rsp_data;

  logic [DW-1:0] mem [0:1023];

  int checks   = 0;
  int failures = 0;

  // Reference model state: integer pointer, owner (-1 = none), burst length.
  int              m_ptr;
  int              m_owner;
  int              m_run;
  logic [NREQ-1:0] m_pend;
  logic [NREQ-1:0] m_rv;
  logic [AW-1:0]   m_pend_addr;
  logic [AW-1:0]   m_data_addr;
  logic [AW-1:0]   m_rom_addr;

  sprite_fetch_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW), .MAX_BURST(MAXB)) dut (
    .clk(clk), .reset(reset), .req(req), .req_addr(req_addr), .req_lock(req_lock),
    .gnt(gnt), .rom_addr(rom_addr), .rom_q(rom_q), .rsp_valid(rsp_valid),
    .rsp_data(rsp_data)
  );

  always #5 clk = ~clk;

  // Sprite ROM: 1-cycle registered read.
  always_ff @(posedge clk) rom_q <= mem[rom_addr];

  function automatic int next_of(input int i);
    return RR_EN ? ((i + 1) % NREQ) : 0;
  endfunction

  function automatic logic [DW-1:0] exp_data();
    return (m_rv != '0) ? mem[m_data_addr] : '0;
  endfunction

  function automatic logic [NREQ-1:0] model_gnt();
    logic [NREQ-1:0] g;
    g = '0;
    if (reset) return g;
    if (m_owner >= 0) begin
      g[m_owner] = req[m_owner];
      return g;
    end
    for (int k = 0; k < NREQ; k++) begin
      int idx;
      idx = (m_ptr + k) % NREQ;
      if (req[idx]) begin
        g[idx] = 1'b1;
        return g;
      end
    end
    return g;
  endfunction

  task automatic model_reset();
    m_ptr = 0; m_owner = -1; m_run = 0;
    m_pend = '0; m_rv = '0;
    m_pend_addr = '0; m_data_addr = '0; m_rom_addr = '0;
  endtask

  // Advance one clock edge and update the model from the pre-edge inputs.
  task automatic tick();
    logic [NREQ-1:0] g;
    int gi;
    g = model_gnt();
    @(posedge clk);
    if (reset) begin
      model_reset();
    end else begin
      m_rv = m_pend;
      m_data_addr = m_pend_addr;
      m_pend = g;
      gi = -1;
      for (int k = 0; k < NREQ; k++) if (g[k]) gi = k;
      if (gi >= 0) begin
        m_pend_addr = req_addr[gi*AW +: AW];
        m_rom_addr  = m_pend_addr;
      end
      if (m_owner < 0) begin
        if (gi >= 0) begin
          if (req_lock[gi]) begin
            m_owner = gi;
            m_run = 1;
          end else begin
            m_ptr = next_of(gi);
          end
        end
      end else if (!req[m_owner]) begin
        m_ptr = next_of(m_owner);
        m_owner = -1;
      end else begin
        m_run = (m_run < MAXB) ? m_run + 1 : MAXB;
        if (!req_lock[m_owner] ||
            ((m_run == MAXB) && ((req & ~(NREQ'(1) << m_owner)) != '0))) begin
          m_ptr = next_of(m_owner);
          m_owner = -1;
        end
      end
    end
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; req = '0; req_lock = '0;
    @(posedge clk); #1;
    reset = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    reset = 1'b1; req = 4'b1111; req_lock = 4'b0000; req_addr = '1;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (gnt !== 4'b0000) begin failures++; $display("FAIL reset_gnt got=%b exp=0000", gnt); end
    checks++; if (rsp_valid !== 4'b0000) begin failures++; $display("FAIL reset_rsp_valid got=%b exp=0000", rsp_valid); end
    checks++; if (rsp_data !== 3'd0) begin failures++; $display("FAIL reset_rsp_data got=%0d exp=0", rsp_data); end
    checks++; if (rom_addr !== 10'd0) begin failures++; $display("FAIL reset_rom_addr got=%h exp=000", rom_addr); end
    reset = 1'b0; req = '0;
    model_reset();
  endtask

  task automatic test_single_beat();
    do_reset();
    req_addr = '0;
    req_addr[2*AW +: AW] = 10'h015;
    req = 4'b0100;
    @(negedge clk);
    checks++; if (gnt !== 4'b0100) begin failures++; $display("FAIL single_gnt got=%b exp=0100", gnt); end
    tick();
    req = 4'b0000;
    checks++; if (rom_addr !== 10'h015) begin failures++; $display("FAIL single_rom_addr got=%h exp=015", rom_addr); end
    checks++; if (rsp_valid !== 4'b0000) begin failures++; $display("FAIL single_early_valid got=%b exp=0000", rsp_valid); end
    tick();
    checks++; if (rsp_valid !== 4'b0100) begin failures++; $display("FAIL single_rsp_valid got=%b exp=0100", rsp_valid); end
    checks++; if (rsp_data !== mem[10'h015]) begin failures++; $display("FAIL single_rsp_data got=%0d exp=%0d", rsp_data, mem[10'h015]); end
    tick();
    checks++; if (rsp_valid !== 4'b0000) begin failures++; $display("FAIL single_valid_drop got=%b exp=0000", rsp_valid); end
    checks++; if (rom_addr !== 10'h015) begin failures++; $display("FAIL single_addr_hold got=%h exp=015", rom_addr); end
  endtask

  task automatic test_all_requests();
    logic [NREQ-1:0] eg [0:7];
    do_reset();
    for (int i = 0; i < NREQ; i++) req_addr[i*AW +: AW] = AW'(10'h100 + i);
    req = 4'b1111; req_lock = 4'b0000;
    for (int c = 0; c < 8; c++) begin
      eg[c] = RR_EN ? (NREQ'(1) << (c % NREQ)) : 4'b0001;
      @(negedge clk);
      checks++; if (gnt !== eg[c]) begin failures++; $display("FAIL all_gnt cyc=%0d got=%b exp=%b", c, gnt, eg[c]); end
      tick();
      checks++; if (rsp_valid !== ((c >= 1) ? eg[c-1] : 4'b0000)) begin
        failures++; $display("FAIL all_rsp_valid cyc=%0d got=%b", c, rsp_valid);
      end
      checks++; if (rsp_data !== exp_data()) begin failures++; $display("FAIL all_rsp_data cyc=%0d got=%0d exp=%0d", c, rsp_data, exp_data()); end
    end
    req = '0;
  endtask

  task automatic test_lock_burst();
    logic [NREQ-1:0] eg;
    do_reset();
    req = 4'b1010; req_lock = 4'b0010;
    for (int c = 0; c < 33; c++) begin
      eg = (c < 32) ? 4'b0010 : (RR_EN ? 4'b1000 : 4'b0010);
      @(negedge clk);
      checks++; if (gnt !== eg) begin failures++; $display("FAIL burst_gnt cyc=%0d got=%b exp=%b", c, gnt, eg); end
      tick();
    end
    req = '0; req_lock = '0;
    tick();
  endtask

  task automatic test_lock_alone();
    do_reset();
    req = 4'b0001; req_lock = 4'b0001;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      checks++; if (gnt !== 4'b0001) begin failures++; $display("FAIL alone_gnt cyc=%0d got=%b exp=0001", c, gnt); end
      tick();
    end
    req = 4'b0010;
    @(negedge clk);
    checks++; if (gnt !== 4'b0000) begin failures++; $display("FAIL alone_drop_gnt got=%b exp=0000", gnt); end
    tick();
    req_lock = 4'b0000;
    @(negedge clk);
    checks++; if (gnt !== 4'b0010) begin failures++; $display("FAIL alone_resume_gnt got=%b exp=0010", gnt); end
    tick();
    req = '0;
  endtask

  task automatic test_reset_inflight();
    do_reset();
    req = 4'b1100; req_lock = 4'b0100;
    tick();
    reset = 1'b1; req = 4'b1111;
    #1;
    checks++; if ({gnt, rsp_valid} !== 8'h00) begin failures++; $display("FAIL inflight_reset_out got=%b%b exp=0", gnt, rsp_valid); end
    checks++; if (rom_addr !== 10'd0 || rsp_data !== 3'd0) begin failures++; $display("FAIL inflight_reset_addr got=%h/%0d exp=0", rom_addr, rsp_data); end
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0; req = '0; req_lock = '0;
    model_reset();
    for (int c = 0; c < 4; c++) begin
      tick();
      checks++; if (rsp_valid !== 4'b0000) begin failures++; $display("FAIL inflight_ghost cyc=%0d got=%b exp=0000", c, rsp_valid); end
    end
    req = 4'b1111;
    @(negedge clk);
    checks++; if (gnt !== 4'b0001) begin failures++; $display("FAIL inflight_first_gnt got=%b exp=0001", gnt); end
    tick();
    req = '0;
  endtask

  task automatic test_priority_mode();
    logic [NREQ-1:0] eg;
    int g3;
    do_reset();
    req = 4'b1010; req_lock = 4'b0000;
    g3 = 0;
    for (int c = 0; c < 10; c++) begin
      eg = RR_EN ? ((c % 2 == 1) ? 4'b1000 : 4'b0010) : 4'b0010;
      @(negedge clk);
      if (gnt[3]) g3++;
      checks++; if (gnt !== eg) begin failures++; $display("FAIL prio_gnt cyc=%0d got=%b exp=%b", c, gnt, eg); end
      tick();
    end
    checks++; if (g3 !== (RR_EN ? 5 : 0)) begin failures++; $display("FAIL prio_req3_count got=%0d exp=%0d", g3, RR_EN ? 5 : 0); end
    req = '0;
  endtask

  task automatic test_random();
    logic [NREQ-1:0] eg;
    do_reset();
    for (int c = 0; c < 600; c++) begin
      for (int i = 0; i < NREQ; i++) begin
        if ($urandom_range(0, 99) < 15) req[i] = ~req[i];
        if ($urandom_range(0, 99) < 10) req_lock[i] = ~req_lock[i];
        req_addr[i*AW +: AW] = AW'($urandom_range(0, 1023));
      end
      eg = model_gnt();
      @(negedge clk);
      checks++; if (gnt !== eg) begin failures++; $display("FAIL rand_gnt cyc=%0d got=%b exp=%b", c, gnt, eg); end
      tick();
      checks++; if (rom_addr !== m_rom_addr) begin failures++; $display("FAIL rand_rom_addr cyc=%0d got=%h exp=%h", c, rom_addr, m_rom_addr); end
      checks++; if (rsp_valid !== m_rv) begin failures++; $display("FAIL rand_rsp_valid cyc=%0d got=%b exp=%b", c, rsp_valid, m_rv); end
      checks++; if (rsp_data !== exp_data()) begin failures++; $display("FAIL rand_rsp_data cyc=%0d got=%0d exp=%0d", c, rsp_data, exp_data()); end
    end
    req = '0; req_lock = '0;
  endtask

  initial begin
    for (int a = 0; a < 1024; a++) mem[a] = DW'($urandom_range(0, 7));
    reset = 1'b1; req = '0; req_lock = '0; req_addr = '0;
    model_reset();
    test_reset();
    test_single_beat();
    test_all_requests();
    test_lock_burst();
    test_lock_alone();
    test_reset_inflight();
    test_priority_mode();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sprite_fetch_arbiter.md
SPRITE_FETCH_ARBITER -- requirements
Module: sprite_fetch_arbiter

Interface
REQ-001 Parameter NREQ, default 4: number of requesters.
REQ-002 Parameter AW, default 10: sprite ROM address width.
REQ-003 Parameter DW, default 3: sprite ROM data width.
REQ-004 Parameter MAX_BURST, default 32: maximum consecutive locked grants, one sprite row.
REQ-005 clk  in  1  single clock; all state changes on its rising edge.
REQ-006 reset  in  1  asynchronous, active-high reset.
REQ-007 req  in  NREQ  per-requester read request.
REQ-008 req_addr  in  NREQ*AW  packed addresses; requester i occupies bits [i*AW +: AW].
REQ-009 req_lock  in  NREQ  requester asks to keep its grant after this beat.
REQ-010 gnt  out  NREQ  one-hot or zero, combinational; gnt[i] at a rising edge means the beat is accepted.
REQ-011 rom_addr  out  AW  registered address to the shared single-port ROM, which has a 1-cycle registered read.
REQ-012 rom_q  in  DW  ROM read data.
REQ-013 rsp_valid  out  NREQ  one-hot, marks the requester that owns rsp_data.
REQ-014 rsp_data  out  DW  equals rom_q when any rsp_valid bit is set, else 0.

Function
REQ-015 The block SHALL accept at most one beat per cycle, sustaining one beat per cycle with no bubbles.
REQ-016 A beat accepted at edge E0 SHALL drive rom_addr = req_addr[i] after E0 and assert rsp_valid[i] with ROM data after E1, for a fixed latency of 2 cycles.
REQ-017 gnt[i] SHALL never assert unless req[i] is asserted in the same cycle.
REQ-018 The FSM SHALL have two states, IDLE and LOCKED, and reset into IDLE.
REQ-019 In IDLE, gnt SHALL select the first asserted req at or after index ptr, searching cyclically.
REQ-020 In IDLE, a grant to i with req_lock[i]=1 SHALL move the FSM to LOCKED with owner=i and cnt=1.
REQ-021 In LOCKED, gnt SHALL equal req[owner] on the owner bit only, and each owner grant SHALL increment cnt, saturating at MAX_BURST.
REQ-022 LOCKED SHALL return to IDLE on any of: an owner grant with req_lock[owner]=0; a cycle with req[owner]=0; or an owner grant with cnt==MAX_BURST while any other req is set.
REQ-023 A cycle with req[owner]=0 in LOCKED SHALL produce no grant; normal arbitration SHALL resume the next cycle.
REQ-024 With no other requester pending, LOCKED SHALL persist past MAX_BURST.
REQ-025 ptr SHALL update to (i+1) mod NREQ on the edge that ends a grant sequence to i: a single IDLE grant or the exit from LOCKED.
REQ-026 Simultaneous release by the owner and a new request: the new request is arbitrated on the following cycle, using the updated ptr.
REQ-027 rom_addr SHALL hold its last value when no beat is accepted.

Reset
REQ-028 While reset is high: gnt=0, rsp_valid=0, rsp_data=0, rom_addr=0, ptr=0, cnt=0, state=IDLE.
REQ-029 Asserting reset mid-burst or with beats in flight SHALL discard those beats; no rsp_valid SHALL follow reset deassertion without a new grant.

Configuration
REQ-030 With SPRITE_ARB_RR_EN defined, ptr SHALL follow REQ-025 (round-robin).
REQ-031 Without SPRITE_ARB_RR_EN, ptr SHALL be held at 0 (fixed priority, index 0 highest); all other behaviour is unchanged.

Verification
REQ-032 RR defined, req=4'b1111 and req_lock=0 held for 8 cycles -> gnt sequence 0001,0010,0100,1000,0001,...; each rsp_valid follows its gnt by 2 cycles.
REQ-033 Requester 2, req_addr=10'h015, single beat -> rom_addr=10'h015 after E0, rsp_valid=4'b0100 and rsp_data=mem[0x15] after E1.
REQ-034 Requester 1 locked with req and lock held, requester 3 requesting -> 32 consecutive gnt=0010, then gnt=1000 on the 33rd cycle.
REQ-035 Requester 0 locked alone for 40 cycles -> 40 consecutive grants with no release.
REQ-036 Reset asserted 1 cycle after a grant -> no rsp_valid afterwards; all outputs 0; the first post-reset grant goes to index 0.
REQ-037 RR undefined, req=4'b1010 held -> gnt=0010 every cycle, and requester 3 is never granted.
